write_buffer: RTL and testbench

Posted-write FIFO between the cache's write-through port and the data memory's write port in the memory unit. Cache stores are accepted in a single cycle and retired to data memory one per cycle whenever the memory signals ready, so that a slow or busy backing memory does not stall the pipeline until the buffer fills. A combinational lookup port forwards the youngest buffered data for a word address, so cache refills never read stale memory contents.

---
 rtl/mem_pkg.sv | 14 +
 rtl/wb_match.sv | 41 ++++
 rtl/write_buffer.sv | 106 ++++++++++
 tb/tb_write_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-unit types and constants: word widths and the write-buffer
// entry layout used by the buffer and its lookup search.
package mem_pkg;

    localparam int DATA_WIDTH         = 32;
    localparam int WORD_ADDRESS_WIDTH = 30;
    localparam int WB_DEPTH_LOG2      = 2;

    typedef struct packed {
        logic [WORD_ADDRESS_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]         data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Combinational store-to-load forwarding search over the write-buffer entries.
// Entries are ranked by age relative to the tail pointer; the youngest match wins.
module wb_match
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = WB_DEPTH_LOG2
) (
    input  wb_entry_t                     entries_i [1 << DEPTH_LOG2],
    input  logic [DEPTH_LOG2-1:0]         tail_i,
    input  logic [DEPTH_LOG2:0]           count_i,
    input  logic [WORD_ADDRESS_WIDTH-1:0] lookup_address_i,
    output logic                          lookup_hit_o,
    output logic [DATA_WIDTH-1:0]         lookup_data_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Age 0 is the most recently written slot (tail - 1), age DEPTH-1 the oldest.
    logic [DEPTH_LOG2-1:0] age_idx [DEPTH];
    logic [DEPTH-1:0]      age_match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_idx[gi]   = tail_i - DEPTH_LOG2'(gi + 1);
            assign age_match[gi] = ((DEPTH_LOG2 + 1)'(gi) < count_i) &&
                                   (entries_i[age_idx[gi]].address == lookup_address_i);
        end
    endgenerate

    always_comb begin
        lookup_hit_o  = |age_match;
        lookup_data_o = '0;
        // Scan oldest to youngest so the youngest matching entry is written last.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (age_match[k]) begin
                lookup_data_o = entries_i[age_idx[k]].data;
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Posted-write FIFO between the cache write-through port and data memory,
// with a combinational forwarding lookup of the youngest buffered store.
module write_buffer
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH    = mem_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = mem_pkg::WORD_ADDRESS_WIDTH,
    parameter int DEPTH_LOG2    = mem_pkg::WB_DEPTH_LOG2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [ADDRESS_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_ready,
    output logic                     mem_write_enable,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic                     mem_ready,
    input  logic [ADDRESS_WIDTH-1:0] lookup_address,
    output logic                     lookup_hit,
    output logic [DATA_WIDTH-1:0]    lookup_data,
    output logic                     empty,
    output logic                     full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    wb_entry_t             entries_q [DEPTH];
    logic                  enq;
    logic                  deq;

    // Flags come from the count alone; pointer equality is ambiguous when full.
    assign full             = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty            = (count_q == '0);
    assign wr_ready         = !full;
    assign mem_write_enable = !empty;

    assign enq = wr_valid && !full;
    assign deq = mem_ready && !empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d = tail_q + 1'b1;
        end
        if (deq) begin
            head_d = head_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never reset; stale contents are masked by count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (enq && (tail_q == DEPTH_LOG2'(gi))) begin
                    entries_q[gi].address <= wr_address;
                    entries_q[gi].data    <= wr_data;
                end
            end
        end
    endgenerate

    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        if (!empty) begin
            mem_address    = entries_q[head_q].address;
            mem_write_data = entries_q[head_q].data;
        end
    end

    wb_match #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_match (
        .entries_i        (entries_q),
        .tail_i           (tail_q),
        .count_i          (count_q),
        .lookup_address_i (lookup_address),
        .lookup_hit_o     (lookup_hit),
        .lookup_data_o    (lookup_data)
    );

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: a queue of pending stores predicts the
// memory-side sequence, the status flags and the forwarding lookup.
module tb_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [29:0] wr_address;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        mem_write_enable;
    logic [29:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_ready;
    logic [29:0] lookup_address;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic        empty;
    logic        full;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t sb_q[$];

    write_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .wr_valid         (wr_valid),
        .wr_address       (wr_address),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_ready        (mem_ready),
        .lookup_address   (lookup_address),
        .lookup_hit       (lookup_hit),
        .lookup_data      (lookup_data),
        .empty            (empty),
        .full             (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Compare every registered-state output and the lookup against the model.
    task automatic check_state(input string tag);
        int          n;
        logic        exp_hit;
        logic [31:0] exp_ld;
        n       = sb_q.size();
        exp_hit = 1'b0;
        exp_ld  = '0;
        foreach (sb_q[i]) begin
            if (sb_q[i].a == lookup_address) begin
                exp_hit = 1'b1;
                exp_ld  = sb_q[i].d;
            end
        end
        check({tag, ".wr_ready"}, 64'(wr_ready), 64'(n < 4));
        check({tag, ".empty"}, 64'(empty), 64'(n == 0));
        check({tag, ".full"}, 64'(full), 64'(n == 4));
        check({tag, ".mem_we"}, 64'(mem_write_enable), 64'(n != 0));
        check({tag, ".mem_addr"}, 64'(mem_address), (n != 0) ? 64'(sb_q[0].a) : 64'd0);
        check({tag, ".mem_data"}, 64'(mem_write_data), (n != 0) ? 64'(sb_q[0].d) : 64'd0);
        check({tag, ".lk_hit"}, 64'(lookup_hit), 64'(exp_hit));
        check({tag, ".lk_data"}, 64'(lookup_data), 64'(exp_ld));
    endtask

    // One clock: drive, check pre-edge outputs, update model, advance past edge.
    task automatic cycle(input string tag, input logic wv, input logic [29:0] wa,
                         input logic [31:0] wd, input logic mr, output logic accepted);
        logic retired;
        wr_valid   = wv;
        wr_address = wa;
        wr_data    = wd;
        mem_ready  = mr;
        #1;
        check_state(tag);
        accepted = wv && (sb_q.size() < 4);
        retired  = mr && (sb_q.size() > 0);
        $display("[%0t] %s wv=%0b a=0x%0h d=0x%0h mr=%0b acc=%0b ret=%0b cnt=%0d",
                 $time, tag, wv, wa, wd, mr, accepted, retired, sb_q.size());
        if (retired) void'(sb_q.pop_front());
        if (accepted) sb_q.push_back('{a: wa, d: wd});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        int   sent;
        int   guard;
        rst            = 1'b1;
        wr_valid       = 1'b1;
        wr_address     = 30'h3;
        wr_data        = 32'h1234;
        mem_ready      = 1'b0;
        lookup_address = 30'h3;

        // Reset held two cycles with a store pending on the input.
        repeat (2) begin
            @(posedge clk);
            #1;
            check_state("reset");
        end
        rst = 1'b0;
        cycle("post_rst_idle", 1'b0, 30'h3, 32'h0, 1'b0, acc);
        check_state("post_rst");

        lookup_address = 30'h10;
        cycle("single_wr", 1'b1, 30'h10, 32'hDEADBEEF, 1'b0, acc);
        cycle("single_hold", 1'b0, 30'h0, 32'h0, 1'b0, acc);
        cycle("single_ret", 1'b0, 30'h0, 32'h0, 1'b1, acc);
        check_state("single_empty");

        // Five back-to-back stores; the fifth must be dropped.
        for (int i = 1; i <= 5; i++) begin
            cycle("fill", 1'b1, 30'(i), 32'h100 + 32'(i), 1'b0, acc);
        end
        for (int i = 0; i < 4; i++) begin
            cycle("drain", 1'b0, 30'h0, 32'h0, 1'b1, acc);
        end
        check_state("drain_done");

        // Full buffer with a store and a retire in the same cycle.
        for (int i = 0; i < 4; i++) begin
            cycle("sim_fill", 1'b1, 30'h30 + 30'(i), 32'hA0 + 32'(i), 1'b0, acc);
        end
        cycle("sim_both", 1'b1, 30'h40, 32'hB0, 1'b1, acc);
        check("sim_rejected", 64'(acc), 64'd0);
        check("sim_cnt3", 64'(sb_q.size()), 64'd3);
        cycle("sim_retry", 1'b1, 30'h40, 32'hB0, 1'b0, acc);
        check("sim_accepted", 64'(acc), 64'd1);
        check_state("sim_full_again");
        for (int i = 0; i < 4; i++) begin
            cycle("sim_drain", 1'b0, 30'h0, 32'h0, 1'b1, acc);
        end

        // Forwarding: youngest match wins, stores in flight are invisible.
        lookup_address = 30'h20;
        cycle("fwd_wr", 1'b1, 30'h20, 32'h1, 1'b0, acc);
        cycle("fwd_wr", 1'b1, 30'h21, 32'h2, 1'b0, acc);
        cycle("fwd_wr", 1'b1, 30'h20, 32'h3, 1'b0, acc);
        cycle("fwd_lk20", 1'b0, 30'h0, 32'h0, 1'b0, acc);
        check("fwd_youngest", 64'(lookup_data), 64'h3);
        cycle("fwd_ret", 1'b0, 30'h0, 32'h0, 1'b1, acc);
        cycle("fwd_ret", 1'b0, 30'h0, 32'h0, 1'b1, acc);
        lookup_address = 30'h21;
        #1;
        check_state("fwd_lk21");
        check("fwd_miss21", 64'(lookup_hit), 64'd0);
        lookup_address = 30'h20;
        #1;
        check_state("fwd_lk20_after");
        cycle("fwd_ret", 1'b0, 30'h0, 32'h0, 1'b1, acc);

        // Wrap: ten stores with random memory back-pressure.
        sent  = 0;
        guard = 0;
        while (sent < 10 && guard < 200) begin
            lookup_address = 30'h50 + 30'($urandom_range(0, 9));
            cycle("wrap", 1'b1, 30'h50 + 30'(sent), 32'hC000 + 32'(sent),
                  1'($urandom_range(0, 1)), acc);
            if (acc) sent++;
            guard++;
        end
        check("wrap_all_sent", 64'(sent), 64'd10);
        guard = 0;
        while (sb_q.size() > 0 && guard < 50) begin
            cycle("wrap_drain", 1'b0, 30'h0, 32'h0, 1'($urandom_range(0, 1)), acc);
            guard++;
        end
        check("wrap_drained", 64'(sb_q.size()), 64'd0);

        // Reset with writes pending discards them.
        cycle("rstp_wr", 1'b1, 30'h70, 32'h7, 1'b0, acc);
        cycle("rstp_wr", 1'b1, 30'h71, 32'h8, 1'b0, acc);
        rst      = 1'b1;
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        lookup_address = 30'h70;
        #1;
        check_state("rstp_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
